// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the iterative RV32M unit.
// Handshake: start is a one-cycle request honoured only while busy is low; done pulses once per completed op.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;

    modport master (
        output start, funct3, SrcA, SrcB, flush,
        input  busy, done, Result
    );

    modport slave (
        input  start, funct3, SrcA, SrcB, flush,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on one 2*WIDTH datapath.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    muldiv_if.slave    bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mlt_q;
    logic               neg_q;
    logic               rneg_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic               a_signed, b_signed, a_neg, b_neg, div_in, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH:0]     rem_shift, trial;
    logic               q_bit;
    logic [WIDTH-1:0]   quo, rem, fin_result;

    // Operand decode: signedness per funct3, magnitudes fed to the unsigned datapath.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:         begin a_signed = 1'b1; b_signed = 1'b0; end
            3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            default:        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        a_neg    = a_signed & bus.SrcA[WIDTH-1];
        b_neg    = b_signed & bus.SrcB[WIDTH-1];
        mag_a    = a_neg ? -bus.SrcA : bus.SrcA;
        mag_b    = b_neg ? -bus.SrcB : bus.SrcB;
        div_in   = bus.funct3[2];
        div_zero = div_in & (bus.SrcB == '0);
    end

    // One iteration of each algorithm; acc_q holds {rem, quo} while dividing.
    always_comb begin
        mul_next  = mlt_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        trial     = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};
        q_bit     = ~trial[WIDTH];
        div_next  = {(q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], q_bit};
    end

    // Sign correction and result selection used in FIN.
    always_comb begin
        prod = neg_q  ? -acc_q : acc_q;
        quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 fin_result = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_result = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_result = quo;
            default:                fin_result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = div_zero ? FIN : CALC;
            CALC: begin
                if (cnt_q == '0) state_d = FIN;
`ifdef MULDIV_EARLY_OUT_EN
                else if (!op_q[2] && (mlt_q[WIDTH-1:1] == '0)) state_d = FIN;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mlt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= (state_q == FIN) && !bus.flush;
            if (state_q == IDLE && bus.start && !bus.flush) begin
                op_q  <= bus.funct3;
                cnt_q <= CW'(WIDTH - 1);
                if (div_in) begin
                    mcand_q <= {{WIDTH{1'b0}}, mag_b};
                    mlt_q   <= '0;
                    rneg_q  <= a_neg;
                    // Divide by zero: preload quotient=all-ones and remainder=|SrcA| so FIN yields the RV32M values.
                    if (div_zero) begin
                        acc_q <= {mag_a, {WIDTH{1'b1}}};
                        neg_q <= 1'b0;
                    end else begin
                        acc_q <= {{WIDTH{1'b0}}, mag_a};
                        neg_q <= a_neg ^ b_neg;
                    end
                end else begin
                    acc_q   <= '0;
                    mcand_q <= {{WIDTH{1'b0}}, mag_a};
                    mlt_q   <= mag_b;
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= 1'b0;
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q - CW'(1);
                if (op_q[2]) begin
                    acc_q <= div_next;
                end else begin
                    acc_q   <= mul_next;
                    mcand_q <= mcand_q << 1;
                    mlt_q   <= mlt_q >> 1;
                end
            end else if (state_q == FIN && !bus.flush) begin
                result_q <= fin_result;
            end
        end
    end

    assign bus.busy   = (state_q == CALC) || (state_q == FIN);
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic/timing model plus literal expectations.
// Honours MULDIV_EARLY_OUT_EN in its latency model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         errs = 0;
    int         checks = 0;
    int         edge_cnt = 0;

    // Model state: one pending op and its expected completion edge.
    logic         pend = 1'b0;
    int           start_edge = 0;
    int           done_edge = 0;
    logic [W-1:0] pend_res = '0;
    logic [W-1:0] model_result = '0;
    logic         fl_pend = 1'b0;
    int           fl_edge = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from start to done: 1 for divide-by-zero, else WIDTH+1 (or bit-length of |multiplier|+1 with early-out).
    function automatic int lat(input logic [2:0] f, input logic [W-1:0] b);
        int           n;
        logic [W-1:0] mb;
        if (f[2] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[2]) begin
            mb = (f == 3'd1 && b[W-1]) ? -b : b;
            n  = 1;
            for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
            return n + 1;
        end
`endif
        n  = W + 1;
        mb = '0;
        return n + int'(mb[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.SrcA   = a;
        bus.SrcB   = b;
        s = edge_cnt + 1;
        if (!pend && !bus.flush) begin
            pend       = 1'b1;
            start_edge = s;
            done_edge  = s + lat(f, b);
            pend_res   = model(f, a, b);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int s, output int l);
        l = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                l = edge_cnt - s;
                break;
            end
        end
        #1;
        chk("done_seen", (l >= 0), 1);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
        int s, l;
        issue(f, a, b, s);
        wait_done(s, l);
        chk(name, bus.Result, exp_res);
        if (exp_lat >= 0) chk({name, "_lat"}, l, exp_lat);
    endtask

    // Compare process: checks every cycle against the timing/arithmetic model.
    always @(negedge clk) begin : cmp
        int   n;
        logic exp_busy, exp_done;
        n = edge_cnt;
        if (fl_pend && n >= fl_edge) begin
            pend    = 1'b0;
            fl_pend = 1'b0;
        end
        exp_done = 1'b0;
        if (pend && n == done_edge) begin
            exp_done     = 1'b1;
            model_result = pend_res;
            pend         = 1'b0;
        end
        exp_busy = pend && (n >= start_edge);
        chk("busy", bus.busy, exp_busy);
        chk("done", bus.done, exp_done);
        chk("result", bus.Result, model_result);
    end

    initial begin : main
        int s, l, nd;
        bus.start = 1'b0; bus.funct3 = '0; bus.SrcA = '0; bus.SrcB = '0; bus.flush = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.Result, 0);
        rst_n = 1'b1;
        tick();

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, -1);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, -1);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, -1);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1);
        run_op("rem_m9_m4", 3'd6, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, -1);
`ifdef MULDIV_EARLY_OUT_EN
        run_op("mul_5_3", 3'd0, 32'd5, 32'd3, 32'd15, 3);
`else
        run_op("mul_5_3", 3'd0, 32'd5, 32'd3, 32'd15, 33);
`endif

        // A start while busy must not disturb the in-flight divide.
        issue(3'd5, 32'd100, 32'd7, s);
        repeat (4) tick();
        issue(3'd0, 32'd3, 32'd3, l);
        wait_done(s, l);
        chk("ignored_start", bus.Result, 32'd14);
        chk("ignored_start_lat", l, 33);

        // Flush at edge 10 of a divide: no done, Result kept.
        tick();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, s);
        repeat (9) tick();
        bus.flush = 1'b1;
        fl_pend   = 1'b1;
        fl_edge   = edge_cnt + 1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_busy", bus.busy, 0);
        chk("flush_result", bus.Result, 32'd14);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        chk("flush_nodone", nd, 0);

        // Asynchronous reset in the middle of CALC.
        tick();
        issue(3'd3, 32'h0000_1234, 32'hFFFF_0000, s);
        repeat (2) tick();
        #2;
        rst_n        = 1'b0;
        pend         = 1'b0;
        model_result = '0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_result", bus.Result, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_op("post_rst_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
